// File: rtl/jt1943_scr_romrd_if.sv
// Bundle of the scroll-generator ROM ports and the SDRAM request port used by
// jt1943_scr_romrd. The master view belongs to the ROM responder; the slave
// view belongs to whatever drives the addresses and plays the SDRAM arbiter.
//
// SDRAM handshake: sdram_req rises with sdram_addr and both hold steady until
// the arbiter answers with a one-cycle sdram_ack; sdram_req drops after the
// ack edge. Read data is then delivered on sdram_data, qualified by a
// one-cycle sdram_dok. Only one request is ever outstanding.
interface jt1943_scr_romrd_if;
    logic [13:0] map_addr;
    logic [15:0] map_data;
    logic        map_ok;
    logic [16:0] scr_addr;
    logic [15:0] scrom_data;
    logic        scr_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_dok;
    logic [15:0] sdram_data;
    logic [1:0]  st_dbg;

    modport master (
        input  map_addr, scr_addr, sdram_ack, sdram_dok, sdram_data,
        output map_data, map_ok, scrom_data, scr_ok, sdram_addr, sdram_req, st_dbg
    );

    modport slave (
        output map_addr, scr_addr, sdram_ack, sdram_dok, sdram_data,
        input  map_data, map_ok, scrom_data, scr_ok, sdram_addr, sdram_req, st_dbg
    );
endinterface

// File: rtl/jt1943_scr_romrd.sv
// ROM responder for one 1943 scroll layer: keeps a one-word cache for the map
// ROM port and one for the tile-graphics ROM port, and refills a stale entry
// from SDRAM. The map port always wins when both entries are stale.
// st_dbg exposes the FSM state (0 idle, 1 waiting ack, 2 waiting data).
module jt1943_scr_romrd #(
    parameter logic [21:0] MAP_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET = 22'h10000
) (
    input logic clk,
    input logic rst,
    jt1943_scr_romrd_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t      st;
    logic        gnt_scr;    // 1: the outstanding fetch belongs to the scroll port
    logic [16:0] gnt_addr;   // port address captured at grant, becomes the tag on fill
    logic [21:0] sdram_addr;
    logic        sdram_req;

    logic [13:0] map_tag;
    logic [15:0] map_data;
    logic        map_valid;
    logic [16:0] scr_tag;
    logic [15:0] scr_data;
    logic        scr_valid;

    logic        map_hit;
    logic        scr_hit;

    // Hit detection is combinational so a cached word is usable the same
    // cycle its address shows up.
    assign map_hit = map_valid && (map_tag == bus.map_addr);
    assign scr_hit = scr_valid && (scr_tag == bus.scr_addr);

    assign bus.map_ok     = map_hit;
    assign bus.scr_ok     = scr_hit;
    assign bus.map_data   = map_data;
    assign bus.scrom_data = scr_data;
    assign bus.sdram_addr = sdram_addr;
    assign bus.sdram_req  = sdram_req;
    assign bus.st_dbg     = st;

    // Fetch sequencer and cache fill. A fill always uses the address latched
    // at grant, so an address that moved mid-fetch simply stays a miss and
    // gets re-granted from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            gnt_scr    <= 1'b0;
            gnt_addr   <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
            map_tag    <= '0;
            map_data   <= '0;
            map_valid  <= 1'b0;
            scr_tag    <= '0;
            scr_data   <= '0;
            scr_valid  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (!map_hit) begin
                        gnt_scr    <= 1'b0;
                        gnt_addr   <= {3'd0, bus.map_addr};
                        sdram_addr <= MAP_OFFSET + {8'd0, bus.map_addr};
                        sdram_req  <= 1'b1;
                        st         <= WAIT_ACK;
                    end else if (!scr_hit) begin
                        gnt_scr    <= 1'b1;
                        gnt_addr   <= bus.scr_addr;
                        sdram_addr <= SCR_OFFSET + {5'd0, bus.scr_addr};
                        sdram_req  <= 1'b1;
                        st         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A dok coinciding with the ack belongs to nobody; only
                    // the ack is taken here.
                    if (bus.sdram_ack) begin
                        sdram_req <= 1'b0;
                        st        <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (bus.sdram_dok) begin
                        if (gnt_scr) begin
                            scr_data  <= bus.sdram_data;
                            scr_tag   <= gnt_addr;
                            scr_valid <= 1'b1;
                        end else begin
                            map_data  <= bus.sdram_data;
                            map_tag   <= gnt_addr[13:0];
                            map_valid <= 1'b1;
                        end
                        st <= IDLE;
                    end
                end
                default: begin
                    st        <= IDLE;
                    sdram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt1943_scr_romrd.sv
// Directed bench for jt1943_scr_romrd: a table of single-port misses with
// hand-computed SDRAM addresses, then hand-written sequences for priority,
// mid-fetch address change, stray ack/dok pulses and reset during a fetch.
module tb_jt1943_scr_romrd;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt1943_scr_romrd_if bus ();

    jt1943_scr_romrd #(
        .MAP_OFFSET(22'h00000),
        .SCR_OFFSET(22'h10000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act);
        logic [31:0] e;
        e = exp_q.pop_front();
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, e);
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] e);
        exp_q.push_back(e);
        chk(name, act);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, hold off ack for ack_dly cycles while
    // checking the address stays put, then present a one-cycle ack.
    task automatic req_ack(input int ack_dly, output logic [21:0] a_seen);
        int guard;
        int unstable;
        guard = 0;
        while (!bus.sdram_req && guard < 20) begin
            tick();
            guard++;
        end
        expect_val("req_seen", {31'd0, bus.sdram_req}, 32'd1);
        a_seen   = bus.sdram_addr;
        unstable = 0;
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            if (!bus.sdram_req || bus.sdram_addr != a_seen) unstable++;
        end
        expect_val("req_addr_stable", unstable, 0);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        expect_val("req_dropped", {31'd0, bus.sdram_req}, 32'd0);
    endtask

    task automatic dok_pulse(input int dok_dly, input logic [15:0] d);
        for (int i = 0; i < dok_dly; i++) tick();
        bus.sdram_dok  = 1'b1;
        bus.sdram_data = d;
        tick();
        bus.sdram_dok  = 1'b0;
        bus.sdram_data = 16'h0000;
    endtask

    task automatic serve(input int ack_dly, input int dok_dly, input logic [15:0] d,
                         output logic [21:0] a_seen);
        req_ack(ack_dly, a_seen);
        dok_pulse(dok_dly, d);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_scr;
        logic [16:0] addr;
        logic [15:0] data;
        logic [21:0] exp_sdram;
        int          ack_dly;
        int          dok_dly;
    } vec_t;

    vec_t vecs[5];
    logic [21:0] a;
    int req_cnt;

    initial begin
        vecs[0] = '{1'b0, 17'h00123, 16'hBEEF, 22'h00123, 0, 3};
        vecs[1] = '{1'b1, 17'h00000, 16'h1234, 22'h10000, 2, 0};
        vecs[2] = '{1'b1, 17'h1FFFF, 16'hC0DE, 22'h2FFFF, 0, 0};
        vecs[3] = '{1'b0, 17'h03FFF, 16'hF00D, 22'h03FFF, 1, 1};
        vecs[4] = '{1'b1, 17'h00040, 16'h4040, 22'h10040, 0, 2};

        bus.map_addr   = 14'h0;
        bus.scr_addr   = 17'h0;
        bus.sdram_ack  = 1'b0;
        bus.sdram_dok  = 1'b0;
        bus.sdram_data = 16'h0;

        // Reset state, addresses at zero match the cleared tags but not valid.
        tick();
        tick();
        expect_val("rst_map_ok",   {31'd0, bus.map_ok}, 32'd0);
        expect_val("rst_scr_ok",   {31'd0, bus.scr_ok}, 32'd0);
        expect_val("rst_req",      {31'd0, bus.sdram_req}, 32'd0);
        expect_val("rst_addr",     {10'd0, bus.sdram_addr}, 32'd0);
        expect_val("rst_map_data", {16'd0, bus.map_data}, 32'd0);
        expect_val("rst_st",       {30'd0, bus.st_dbg}, 32'd0);
        rst = 1'b0;

        // Table of single-port misses.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_scr) bus.scr_addr = vecs[i].addr;
            else                bus.map_addr = vecs[i].addr[13:0];
            serve(vecs[i].ack_dly, vecs[i].dok_dly, vecs[i].data, a);
            expect_val($sformatf("vec%0d_sdram_addr", i), {10'd0, a}, {10'd0, vecs[i].exp_sdram});
            if (vecs[i].is_scr) begin
                expect_val($sformatf("vec%0d_scr_ok", i), {31'd0, bus.scr_ok}, 32'd1);
                expect_val($sformatf("vec%0d_scr_data", i), {16'd0, bus.scrom_data}, {16'd0, vecs[i].data});
            end else begin
                expect_val($sformatf("vec%0d_map_ok", i), {31'd0, bus.map_ok}, 32'd1);
                expect_val($sformatf("vec%0d_map_data", i), {16'd0, bus.map_data}, {16'd0, vecs[i].data});
            end
        end

        // Both cached: no SDRAM traffic while addresses are held.
        req_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.sdram_req) req_cnt++;
        end
        expect_val("hit_no_req", req_cnt, 0);
        expect_val("hit_map_ok", {31'd0, bus.map_ok}, 32'd1);
        expect_val("hit_scr_ok", {31'd0, bus.scr_ok}, 32'd1);

        // Simultaneous misses: map first, scr granted on the edge after the map fill.
        bus.map_addr = 14'h0010;
        bus.scr_addr = 17'h10001;
        serve(0, 0, 16'hA0A0, a);
        expect_val("pri_first_addr", {10'd0, a}, 32'h00010);
        expect_val("pri_map_ok",     {31'd0, bus.map_ok}, 32'd1);
        expect_val("pri_scr_wait",   {31'd0, bus.scr_ok}, 32'd0);
        tick();
        expect_val("pri_second_req",  {31'd0, bus.sdram_req}, 32'd1);
        expect_val("pri_second_addr", {10'd0, bus.sdram_addr}, 32'h20001);
        serve(0, 0, 16'hB0B0, a);
        expect_val("pri_scr_ok",   {31'd0, bus.scr_ok}, 32'd1);
        expect_val("pri_scr_data", {16'd0, bus.scrom_data}, 32'h0000B0B0);

        // Scroll address moves while the fetch is in WAIT_DATA.
        bus.scr_addr = 17'h00005;
        req_ack(0, a);
        expect_val("chg_first_addr", {10'd0, a}, 32'h10005);
        bus.scr_addr = 17'h00006;
        dok_pulse(0, 16'h1111);
        expect_val("chg_scr_ok_low", {31'd0, bus.scr_ok}, 32'd0);
        expect_val("chg_old_fill",   {16'd0, bus.scrom_data}, 32'h00001111);
        serve(0, 0, 16'h2222, a);
        expect_val("chg_refetch_addr", {10'd0, a}, 32'h10006);
        expect_val("chg_scr_ok",       {31'd0, bus.scr_ok}, 32'd1);
        expect_val("chg_scr_data",     {16'd0, bus.scrom_data}, 32'h00002222);

        // Stray dok in IDLE, in WAIT_ACK, and together with ack.
        bus.sdram_dok  = 1'b1;
        bus.sdram_data = 16'hDEAD;
        tick();
        bus.sdram_dok  = 1'b0;
        expect_val("idle_dok_st",       {30'd0, bus.st_dbg}, 32'd0);
        expect_val("idle_dok_map_data", {16'd0, bus.map_data}, 32'h0000A0A0);
        expect_val("idle_dok_scr_data", {16'd0, bus.scrom_data}, 32'h00002222);
        bus.map_addr = 14'h0200;
        tick();
        expect_val("wack_st", {30'd0, bus.st_dbg}, 32'd1);
        bus.sdram_dok = 1'b1;
        tick();
        bus.sdram_dok = 1'b0;
        expect_val("wack_dok_st", {30'd0, bus.st_dbg}, 32'd1);
        bus.sdram_ack = 1'b1;
        bus.sdram_dok = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_dok = 1'b0;
        expect_val("ackdok_st",       {30'd0, bus.st_dbg}, 32'd2);
        expect_val("ackdok_map_ok",   {31'd0, bus.map_ok}, 32'd0);
        expect_val("ackdok_map_data", {16'd0, bus.map_data}, 32'h0000A0A0);
        dok_pulse(1, 16'h5555);
        expect_val("late_dok_map_ok",   {31'd0, bus.map_ok}, 32'd1);
        expect_val("late_dok_map_data", {16'd0, bus.map_data}, 32'h00005555);

        // Reset pulse during WAIT_DATA, then a dok after reset.
        bus.map_addr = 14'h0300;
        req_ack(0, a);
        expect_val("rmid_addr", {10'd0, a}, 32'h00300);
        #3 rst = 1'b1;
        #1;
        expect_val("rmid_st",     {30'd0, bus.st_dbg}, 32'd0);
        expect_val("rmid_map_ok", {31'd0, bus.map_ok}, 32'd0);
        expect_val("rmid_scr_ok", {31'd0, bus.scr_ok}, 32'd0);
        tick();
        expect_val("rmid_req_held", {31'd0, bus.sdram_req}, 32'd0);
        rst = 1'b0;
        bus.sdram_dok  = 1'b1;
        bus.sdram_data = 16'h7777;
        tick();
        bus.sdram_dok  = 1'b0;
        expect_val("rmid_no_fill",    {16'd0, bus.map_data}, 32'd0);
        expect_val("rmid_regrant_st", {30'd0, bus.st_dbg}, 32'd1);
        expect_val("rmid_regrant",    {10'd0, bus.sdram_addr}, 32'h00300);
        serve(0, 0, 16'h8888, a);
        expect_val("rmid_map_ok_after", {31'd0, bus.map_ok}, 32'd1);
        serve(0, 0, 16'h9999, a);
        expect_val("rmid_scr_addr",     {10'd0, a}, 32'h10006);
        expect_val("rmid_scr_ok_after", {31'd0, bus.scr_ok}, 32'd1);

        // Asynchronous reset mid-cycle with a request in flight and map_addr=0.
        bus.map_addr = 14'h0000;
        tick();
        expect_val("areq_req", {31'd0, bus.sdram_req}, 32'd1);
        #3 rst = 1'b1;
        #1;
        expect_val("arst_req",    {31'd0, bus.sdram_req}, 32'd0);
        expect_val("arst_map_ok", {31'd0, bus.map_ok}, 32'd0);
        expect_val("arst_scr_ok", {31'd0, bus.scr_ok}, 32'd0);
        expect_val("arst_addr",   {10'd0, bus.sdram_addr}, 32'd0);
        req_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.sdram_req) req_cnt++;
        end
        expect_val("arst_no_req", req_cnt, 0);
        rst = 1'b0;
        tick();

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
